// File: rtl/ialu_issue_stage.sv
// ----------------------------------------------------------------------------
// ialu_issue_stage
// ID/EX register stage in front of the integer ALU. It captures decoded
// instructions, resolves Rs1/Rs2 through EX/WB forwarding, and presents the
// ALU controls from registers. A divide holds decode off until the divider
// reports completion. A flush (taken branch) squashes whatever is in the stage.
//
// Ports
//   CLK, rst_n             clock, async active-low reset
//   id_*                   decoded instruction from decode (id_valid/id_ready)
//   fwd_ex_*, fwd_wb_*     forwarding sources (EX result, WB result)
//   div_done               divider completion
//   flush                  squash issued instruction, block accept
//   ex_valid, Rs1, Rs2,
//   IALU_ctrl, Funct3,
//   Funct7_5, Add_Op,
//   ex_rd_addr,
//   ex_reg_write           registered ALU-facing outputs (IALU_ctrl=all ones
//                          means bubble)
//   div_start              one-cycle pulse when a divide is first presented
//   stall                  !id_ready
// ----------------------------------------------------------------------------
module ialu_issue_stage #(
  parameter int XLEN     = 32,
  parameter int REG_ADDR = 5,
  parameter int CTRL_W   = 3
) (
  input  logic                CLK,
  input  logic                rst_n,
  input  logic                id_valid,
  output logic                id_ready,
  input  logic [XLEN-1:0]     id_rs1_data,
  input  logic [XLEN-1:0]     id_rs2_data,
  input  logic [REG_ADDR-1:0] id_rs1_addr,
  input  logic [REG_ADDR-1:0] id_rs2_addr,
  input  logic [REG_ADDR-1:0] id_rd_addr,
  input  logic                id_reg_write,
  input  logic [CTRL_W-1:0]   id_ctrl,
  input  logic [2:0]          id_funct3,
  input  logic                id_funct7_5,
  input  logic                id_add_op,
  input  logic                fwd_ex_we,
  input  logic [REG_ADDR-1:0] fwd_ex_rd,
  input  logic [XLEN-1:0]     fwd_ex_data,
  input  logic                fwd_wb_we,
  input  logic [REG_ADDR-1:0] fwd_wb_rd,
  input  logic [XLEN-1:0]     fwd_wb_data,
  input  logic                div_done,
  input  logic                flush,
  output logic                ex_valid,
  output logic [XLEN-1:0]     Rs1,
  output logic [XLEN-1:0]     Rs2,
  output logic [CTRL_W-1:0]   IALU_ctrl,
  output logic [2:0]          Funct3,
  output logic                Funct7_5,
  output logic                Add_Op,
  output logic [REG_ADDR-1:0] ex_rd_addr,
  output logic                ex_reg_write,
  output logic                div_start,
  output logic                stall
);

  localparam logic [CTRL_W-1:0] CTRL_DIV    = CTRL_W'(3'b010);
  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '1;

  typedef enum logic {IDLE, DIV_WAIT} state_t;

  state_t r_state, w_state_nxt;

  logic                r_ex_valid;
  logic [XLEN-1:0]     r_rs1, r_rs2;
  logic [CTRL_W-1:0]   r_ctrl;
  logic [2:0]          r_funct3;
  logic                r_funct7_5;
  logic                r_add_op;
  logic [REG_ADDR-1:0] r_rd_addr;
  logic                r_reg_write;
  logic                r_div_start;

  logic                w_id_ready;
  logic                w_accept;
  logic                w_is_div;
  logic [XLEN-1:0]     w_rs1_fwd, w_rs2_fwd;

  assign w_id_ready = (r_state == IDLE) && !flush;
  assign w_accept   = id_valid && w_id_ready;
  assign w_is_div   = (id_ctrl == CTRL_DIV);

  // Forwarding: EX beats WB (it is younger); x0 is hardwired zero so it is
  // never forwarded.
  always_comb begin
    w_rs1_fwd = id_rs1_data;
    if (id_rs1_addr != '0) begin
      if (fwd_ex_we && fwd_ex_rd == id_rs1_addr)      w_rs1_fwd = fwd_ex_data;
      else if (fwd_wb_we && fwd_wb_rd == id_rs1_addr) w_rs1_fwd = fwd_wb_data;
    end
  end

  always_comb begin
    w_rs2_fwd = id_rs2_data;
    if (id_rs2_addr != '0) begin
      if (fwd_ex_we && fwd_ex_rd == id_rs2_addr)      w_rs2_fwd = fwd_ex_data;
      else if (fwd_wb_we && fwd_wb_rd == id_rs2_addr) w_rs2_fwd = fwd_wb_data;
    end
  end

  // FSM state register
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state; flush aborts a divide wait and masks a coincident div_done
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:     if (w_accept && w_is_div) w_state_nxt = DIV_WAIT;
        DIV_WAIT: if (div_done)             w_state_nxt = IDLE;
        default:  w_state_nxt = IDLE;
      endcase
    end
  end

  // ID/EX register. A bubble only kills valid/ctrl/reg_write; operand and
  // field registers hold so the ALU inputs don't toggle needlessly.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid  <= 1'b0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_ctrl      <= CTRL_BUBBLE;
      r_funct3    <= '0;
      r_funct7_5  <= 1'b0;
      r_add_op    <= 1'b0;
      r_rd_addr   <= '0;
      r_reg_write <= 1'b0;
      r_div_start <= 1'b0;
    end else if (flush) begin
      r_ex_valid  <= 1'b0;
      r_ctrl      <= CTRL_BUBBLE;
      r_reg_write <= 1'b0;
      r_div_start <= 1'b0;
    end else if (r_state == IDLE) begin
      if (w_accept) begin
        r_ex_valid  <= 1'b1;
        r_rs1       <= w_rs1_fwd;
        r_rs2       <= w_rs2_fwd;
        r_ctrl      <= id_ctrl;
        r_funct3    <= id_funct3;
        r_funct7_5  <= id_funct7_5;
        r_add_op    <= id_add_op;
        r_rd_addr   <= id_rd_addr;
        r_reg_write <= id_reg_write;
        r_div_start <= w_is_div;
      end else begin
        r_ex_valid  <= 1'b0;
        r_ctrl      <= CTRL_BUBBLE;
        r_reg_write <= 1'b0;
        r_div_start <= 1'b0;
      end
    end else begin
      // DIV_WAIT: everything frozen except the start pulse, until done
      r_div_start <= 1'b0;
      if (div_done) begin
        r_ex_valid  <= 1'b0;
        r_ctrl      <= CTRL_BUBBLE;
        r_reg_write <= 1'b0;
      end
    end
  end

  assign id_ready     = w_id_ready;
  assign stall        = !w_id_ready;
  assign ex_valid     = r_ex_valid;
  assign Rs1          = r_rs1;
  assign Rs2          = r_rs2;
  assign IALU_ctrl    = r_ctrl;
  assign Funct3       = r_funct3;
  assign Funct7_5     = r_funct7_5;
  assign Add_Op       = r_add_op;
  assign ex_rd_addr   = r_rd_addr;
  assign ex_reg_write = r_reg_write && r_ex_valid;
  assign div_start    = r_div_start;

endmodule
